b_bit_decoder: RTL and testbench
================================

B_BIT_DECODER -- requirements
Module: b_bit_decoder

Interface
REQ-001 SHALL have parameter SKIP_BITS, default 48, PLCP header bits discarded after SFD before payload.
REQ-002 SHALL have parameter FRAME_BYTES, default 38, payload bytes per frame including 4-byte FCS; legal range 5..255.
REQ-003 SHALL have parameter SFD, default 16'hF3A0, start-frame delimiter, received LSB first.
REQ-004 SHALL have port clk  input  1  system clock (50 MHz); all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port enable  input  1  frame gate; low forces IDLE.
REQ-007 SHALL have port bit_valid  input  1  one-cycle strobe, one per 1 us symbol.
REQ-008 SHALL have port phase_in  input  1  hard-decision DBPSK phase, sampled when bit_valid=1.
REQ-009 SHALL have port byte_data  output  8  assembled payload byte.
REQ-010 SHALL have port byte_valid  output  1  one-cycle strobe qualifying byte_data.
REQ-011 SHALL have port sfd_found  output  1  one-cycle pulse on SFD match.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse after last frame byte.
REQ-013 SHALL have port crc_ok  output  1  FCS check result, valid from frame_done.
REQ-014 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-015 SHALL process exactly one bit per bit_valid=1 cycle and ignore phase_in otherwise.
REQ-016 SHALL differentially decode: d = phase_in XOR prev_phase; prev_phase updated to phase_in on each accepted bit.
REQ-017 SHALL descramble self-synchronously: out = d XOR s[3] XOR s[6]; s = 7-bit history of d, s[0] newest; runs on every accepted bit in all non-IDLE states.
REQ-018 SHALL implement states IDLE, SEARCH, SKIP, PAYLOAD, DONE.
REQ-019 IDLE: enable=1 -> SEARCH next cycle; prev_phase, s, sfd shift register, counters cleared.
REQ-020 SEARCH: 16-bit register shifts descrambled bits in at bit 15; on value == SFD -> SKIP, sfd_found pulses one cycle after the matching bit_valid.
REQ-021 SKIP: count SKIP_BITS accepted bits, then -> PAYLOAD; SKIP_BITS=0 -> PAYLOAD directly from SEARCH.
REQ-022 PAYLOAD: assemble bytes LSB first; byte_valid pulses one cycle after the bit_valid carrying bit 7; byte_data held until next byte.
REQ-023 SHALL compute bit-serial reflected CRC-32 (poly 0xEDB88320, init 0xFFFFFFFF, no final inversion) over all FRAME_BYTES*8 payload bits including FCS; CRC reinitialised on SFD match.
REQ-024 After FRAME_BYTES-th byte_valid -> DONE; frame_done pulses the cycle after that byte_valid; crc_ok = (CRC register == 0xDEBB20E3) registered with frame_done.
REQ-025 DONE: hold crc_ok; ignore bits; remain until enable=0.
REQ-026 enable=0 in any state -> IDLE next cycle, overriding a coincident bit_valid; partial byte discarded; no byte_valid or frame_done issued.
REQ-027 crc_ok SHALL clear on sfd_found and on reset only; it holds through enable=0.
REQ-028 Byte counter 8 bits; bit counter 6 bits; no wrap within a frame.
REQ-029 byte_valid, sfd_found, frame_done SHALL never exceed one cycle and SHALL be mutually exclusive in a cycle.

Reset
REQ-030 reset=1 SHALL dominate enable and bit_valid and force IDLE.
REQ-031 Reset values: byte_data=8'h00, byte_valid=0, sfd_found=0, frame_done=0, crc_ok=0, busy=0; all internal registers zero except CRC=0xFFFFFFFF.
REQ-032 reset mid-PAYLOAD SHALL discard the frame with no further strobes.

Verification
REQ-033 128 scrambled 1s preamble + SFD 0xF3A0 + 48 header bits + 34 bytes 0x00..0x21 + correct FCS, DBPSK-encoded -> sfd_found once, 38 byte_valid with bytes 0x00..0x21 then FCS, frame_done, crc_ok=1.
REQ-034 Same frame with payload byte 5 bit 0 flipped -> 38 byte_valid, byte 5 = 0x04, crc_ok=0.
REQ-035 enable dropped after 10th byte -> busy=0 within 1 cycle, no further byte_valid, no frame_done.
REQ-036 Preamble only, no SFD, 2000 bits -> state SEARCH, no strobes, busy=1.
REQ-037 bit_valid spacing 50 cycles vs 1 cycle (back-to-back) -> identical byte sequence and crc_ok.
REQ-038 reset asserted during PAYLOAD, then full good frame -> all outputs at reset values, then REQ-033 response.

Source files
------------

// File: rtl/b_bit_decoder.sv
// DBPSK bit-stream frame decoder: differential decode, self-synchronous descrambling,
// SFD search, header skip, LSB-first byte assembly and bit-serial CRC-32 check.
`timescale 1ns/1ps
module b_bit_decoder #(
  parameter int unsigned SKIP_BITS   = 48,
  parameter int unsigned FRAME_BYTES = 38,
  parameter logic [15:0] SFD         = 16'hF3A0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       bit_valid,
  input  logic       phase_in,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       sfd_found,
  output logic       frame_done,
  output logic       crc_ok,
  output logic       busy
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SEARCH  = 3'd1;
  localparam logic [2:0] ST_SKIP    = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [5:0]  SKIP_LAST   = 6'(SKIP_BITS - 1);
  localparam logic [7:0]  LAST_BYTE   = 8'(FRAME_BYTES - 1);

  logic [2:0]  state_q, state_d;
  logic        prev_phase_q, prev_phase_d;
  logic [6:0]  scr_q, scr_d;
  logic [15:0] sfd_sr_q, sfd_sr_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  byte_data_q, byte_data_d;
  logic        byte_valid_q, byte_valid_d;
  logic        sfd_found_q, sfd_found_d;
  logic        frame_done_q, frame_done_d;
  logic        crc_ok_q, crc_ok_d;

  logic        d_bit, out_bit, crc_fb;
  logic [15:0] sfd_next;
  logic [31:0] crc_next;
  logic [7:0]  shift_next;

  always_comb begin
    d_bit      = phase_in ^ prev_phase_q;
    out_bit    = d_bit ^ scr_q[3] ^ scr_q[6];
    sfd_next   = {out_bit, sfd_sr_q[15:1]};
    shift_next = {out_bit, shift_q[7:1]};
    crc_fb     = crc_q[0] ^ out_bit;
    crc_next   = {1'b0, crc_q[31:1]} ^ (crc_fb ? CRC_POLY : '0);
  end

  always_comb begin
    state_d      = state_q;
    prev_phase_d = prev_phase_q;
    scr_d        = scr_q;
    sfd_sr_d     = sfd_sr_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    crc_d        = crc_q;
    byte_data_d  = byte_data_q;
    crc_ok_d     = crc_ok_q;
    byte_valid_d = 1'b0;
    sfd_found_d  = 1'b0;
    frame_done_d = 1'b0;

    if (!enable) begin
      // Dropping enable beats a coincident bit; IDLE wipes the partial frame next cycle.
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      prev_phase_d = 1'b0;
      scr_d        = '0;
      sfd_sr_d     = '0;
      bit_cnt_d    = '0;
      byte_cnt_d   = '0;
      shift_d      = '0;
      state_d      = ST_SEARCH;
    end else begin
      if (bit_valid) begin
        prev_phase_d = phase_in;
        scr_d        = {scr_q[5:0], d_bit};
        case (state_q)
          ST_SEARCH: begin
            sfd_sr_d = sfd_next;
            if (sfd_next == SFD) begin
              sfd_found_d = 1'b1;
              crc_ok_d    = 1'b0;
              crc_d       = CRC_INIT;
              bit_cnt_d   = '0;
              byte_cnt_d  = '0;
              shift_d     = '0;
              state_d     = (SKIP_BITS == 0) ? ST_PAYLOAD : ST_SKIP;
            end
          end
          ST_SKIP: begin
            if (bit_cnt_q == SKIP_LAST) begin
              bit_cnt_d = '0;
              state_d   = ST_PAYLOAD;
            end else begin
              bit_cnt_d = bit_cnt_q + 6'd1;
            end
          end
          ST_PAYLOAD: begin
            crc_d   = crc_next;
            shift_d = shift_next;
            if (bit_cnt_q == 6'd7) begin
              bit_cnt_d    = '0;
              byte_data_d  = shift_next;
              byte_valid_d = 1'b1;
              byte_cnt_d   = byte_cnt_q + 8'd1;
              if (byte_cnt_q == LAST_BYTE) state_d = ST_DONE;
            end else begin
              bit_cnt_d = bit_cnt_q + 6'd1;
            end
          end
          default: ;
        endcase
      end
      // The final byte strobe is always the first cycle spent in DONE.
      if (state_q == ST_DONE && byte_valid_q) begin
        frame_done_d = 1'b1;
        crc_ok_d     = (crc_q == CRC_RESIDUE);
      end
      if (state_q > ST_DONE) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      prev_phase_q <= 1'b0;
      scr_q        <= '0;
      sfd_sr_q     <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      crc_q        <= CRC_INIT;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      sfd_found_q  <= 1'b0;
      frame_done_q <= 1'b0;
      crc_ok_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_phase_q <= prev_phase_d;
      scr_q        <= scr_d;
      sfd_sr_q     <= sfd_sr_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      crc_q        <= crc_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      sfd_found_q  <= sfd_found_d;
      frame_done_q <= frame_done_d;
      crc_ok_q     <= crc_ok_d;
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign sfd_found  = sfd_found_q;
  assign frame_done = frame_done_q;
  assign crc_ok     = crc_ok_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_b_bit_decoder.sv
// Bench for b_bit_decoder: a scrambling DBPSK transmitter model feeds frames
// from a vector table; a scoreboard queue checks every received byte.
`timescale 1ns/1ps
module tb_b_bit_decoder;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       bit_valid;
  logic       phase_in;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       sfd_found;
  logic       frame_done;
  logic       crc_ok;
  logic       busy;

  b_bit_decoder #(.SKIP_BITS(48), .FRAME_BYTES(38), .SFD(16'hF3A0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bit_valid(bit_valid),
    .phase_in(phase_in), .byte_data(byte_data), .byte_valid(byte_valid),
    .sfd_found(sfd_found), .frame_done(frame_done), .crc_ok(crc_ok), .busy(busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard / strobe monitor
  logic [7:0] exp_q[$];
  int   bv_cnt, sfd_cnt, fd_cnt;
  logic crc_at_done;
  logic prev_bv = 1'b0;

  always @(negedge clk) begin
    if (byte_valid) begin
      bv_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL byte_extra: got %0h, expected no byte (t=%0t)", byte_data, $time);
      end else begin
        chk("byte_data", 32'(byte_data), 32'(exp_q.pop_front()));
      end
    end
    if (sfd_found) sfd_cnt++;
    if (frame_done) begin
      fd_cnt++;
      crc_at_done = crc_ok;
      chk("done_after_byte", 32'(prev_bv), 32'd1);
    end
    if (byte_valid || sfd_found || frame_done)
      chk("strobe_excl", 32'(byte_valid) + 32'(sfd_found) + 32'(frame_done), 32'd1);
    prev_bv = byte_valid;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Transmitter model: scramble, then differentially encode
  logic       tx_prev;
  logic [6:0] tx_s;

  task automatic send_bit(input logic b, input int spacing);
    logic d;
    d       = b ^ tx_s[3] ^ tx_s[6];
    tx_s    = {tx_s[5:0], d};
    tx_prev = tx_prev ^ d;
    phase_in  = tx_prev;
    bit_valid = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    phase_in  = 1'($urandom);
    repeat (spacing - 1) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_byte_data"},  32'(byte_data),  32'h0);
    chk({tag, "_byte_valid"}, 32'(byte_valid), 32'h0);
    chk({tag, "_sfd_found"},  32'(sfd_found),  32'h0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'h0);
    chk({tag, "_crc_ok"},     32'(crc_ok),     32'h0);
    chk({tag, "_busy"},       32'(busy),       32'h0);
  endtask

  task automatic clear_monitor();
    bv_cnt = 0; sfd_cnt = 0; fd_cnt = 0; crc_at_done = 1'b0;
    exp_q.delete();
    tx_s = '0; tx_prev = 1'b0;
  endtask

  logic [7:0] frame[38];

  function automatic logic [31:0] fcs32(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, frame[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  typedef struct {
    int spacing;
    int flip_byte;
    int drop_after;
    int reset_after;
    int exp_bytes;
    bit exp_done;
    bit exp_crc;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input int idx);
    logic [15:0] sfd_v;
    logic [7:0]  b8;
    logic        live;
    int          w;
    sfd_v = 16'hF3A0;
    clear_monitor();
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    live = 1'b1;
    repeat (128) send_bit(1'b1, v.spacing);
    for (int i = 0; i < 16; i++) send_bit(sfd_v[i], v.spacing);
    for (int i = 0; i < 48; i++) send_bit(1'(i % 3 == 1), v.spacing);
    for (int b = 0; b < 38; b++) begin
      b8 = frame[b] ^ ((b == v.flip_byte) ? 8'h01 : 8'h00);
      if (live) exp_q.push_back(b8);
      for (int k = 0; k < 8; k++) send_bit(b8[k], v.spacing);
      if (live && b + 1 == v.drop_after) begin
        enable = 1'b0;
        @(posedge clk); #1;
        chk("busy_after_drop", 32'(busy), 32'd0);
        live = 1'b0;
      end
      if (live && b + 1 == v.reset_after) begin
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("mid_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        break;
      end
    end
    if (v.exp_done) begin
      w = 0;
      while (fd_cnt == 0 && w < 50) begin @(posedge clk); #1; w++; end
      chk("frame_done_cnt", fd_cnt, 1);
      chk("crc_ok_at_done", 32'(crc_at_done), 32'(v.exp_crc));
      chk("busy_in_done", 32'(busy), 32'd1);
    end else begin
      repeat (20) @(posedge clk);
      #1;
      chk("no_frame_done", fd_cnt, 0);
    end
    chk("sfd_cnt", sfd_cnt, (v.reset_after > 0 || v.drop_after > 0 || v.exp_done) ? 1 : 0);
    chk("byte_cnt", bv_cnt, v.exp_bytes);
    chk("queue_empty", exp_q.size(), 0);
    chk("crc_ok_end", 32'(crc_ok), 32'(v.exp_crc));
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("crc_ok_hold", 32'(crc_ok), 32'(v.exp_crc));
    chk("busy_idle", 32'(busy), 32'd0);
    if (n_fail > 0) $display("  (vector %0d complete)", idx);
  endtask

  initial begin
    logic [31:0] fcs;
    reset = 1'b1; enable = 1'b0; bit_valid = 1'b0; phase_in = 1'b0;
    clear_monitor();
    for (int i = 0; i < 34; i++) frame[i] = 8'(i);
    fcs = fcs32(34);
    for (int i = 0; i < 4; i++) frame[34 + i] = fcs[8*i +: 8];

    //        spacing flip drop rst bytes done crc
    vecs[0] = '{50, -1, 0,  0,  38, 1'b1, 1'b1};
    vecs[1] = '{1,  -1, 0,  0,  38, 1'b1, 1'b1};
    vecs[2] = '{3,   5, 0,  0,  38, 1'b1, 1'b0};
    vecs[3] = '{2,  -1, 10, 0,  10, 1'b0, 1'b0};
    vecs[4] = '{2,  -1, 0,  10, 10, 1'b0, 1'b0};
    vecs[5] = '{1,  -1, 0,  0,  38, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    enable = 1'b1;
    bit_valid = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("reset");
    bit_valid = 1'b0;
    enable = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Preamble only: decoder must stay searching without any strobe
    clear_monitor();
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    repeat (2000) send_bit(1'b1, 2);
    repeat (5) @(posedge clk);
    #1;
    chk("pre_sfd_cnt",  sfd_cnt, 0);
    chk("pre_byte_cnt", bv_cnt, 0);
    chk("pre_done_cnt", fd_cnt, 0);
    chk("pre_busy",     32'(busy), 32'd1);
    enable = 1'b0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
